// File: rtl/axi_rd_arbiter_pkg.sv
// Shared constants, FSM state and grant encodings for the AXI read arbiter
// and its line buffer.
package axi_rd_arbiter_pkg;

  localparam int unsigned CACHELINE_WIDTH = 512;

  localparam logic [3:0] ARID_ICACHE  = 4'd0;
  localparam logic [3:0] ARID_DCACHE  = 4'd1;
  localparam logic [3:0] ARID_UNCACHE = 4'd2;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_4B    = 3'b010;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AR   = 2'd1,
    S_R    = 2'd2,
    S_DONE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    G_ICACHE  = 2'd0,
    G_DCACHE  = 2'd1,
    G_UNCACHE = 2'd2
  } grant_e;

  function automatic logic [2:0] grant_onehot(input grant_e g);
    logic [2:0] oh;
    oh = '0;
    case (g)
      G_ICACHE:  oh = 3'b001;
      G_DCACHE:  oh = 3'b010;
      G_UNCACHE: oh = 3'b100;
      default:   oh = '0;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/axi_rd_linebuf.sv
// Beat counter and cache-line assembly register: accepted beats land in
// successive 32-bit words, saturating on the top word.
module axi_rd_linebuf
  import axi_rd_arbiter_pkg::*;
#(
  parameter int unsigned BEATS  = 16,
  parameter int unsigned LINE_W = CACHELINE_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic              i_clear_upper,
  input  logic              i_we,
  input  logic [31:0]       i_wdata,
  output logic [LINE_W-1:0] o_line
);

  localparam int unsigned   CW   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  logic [CW-1:0]     r_cnt;
  logic [LINE_W-1:0] r_line;
  logic [BEATS-1:0]  w_word_we;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_start) begin
      r_cnt <= '0;
    end else if (i_we && (r_cnt != LAST)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_comb begin
    w_word_we = '0;
    for (int unsigned b = 0; b < BEATS; b++) begin
      w_word_we[b] = i_we && (r_cnt == CW'(b));
    end
  end

  // Word 0 is never cleared at grant: an uncache read always overwrites it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_line <= '0;
    end else begin
      for (int unsigned b = 0; b < BEATS; b++) begin
        if (w_word_we[b]) begin
          r_line[32*b +: 32] <= i_wdata;
        end else if ((b != 0) && i_start && i_clear_upper) begin
          r_line[32*b +: 32] <= '0;
        end
      end
    end
  end

  assign o_line = r_line;

endmodule

// File: rtl/axi_rd_arbiter.sv
// Single-outstanding AXI read arbiter for icache, dcache and uncache misses.
// Optional AXI_RD_RR_EN: round-robin between icache and dcache.
module axi_rd_arbiter
  import axi_rd_arbiter_pkg::*;
#(
  parameter int unsigned BEATS  = 16,
  parameter int unsigned LINE_W = CACHELINE_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        req,
  input  logic [31:0]       ic_addr,
  input  logic [31:0]       dc_addr,
  input  logic [31:0]       uc_addr,
  input  logic [2:0]        uc_size,
  output logic [LINE_W-1:0] line_data,
  output logic [2:0]        done,
  output logic [3:0]        arid,
  output logic [31:0]       araddr,
  output logic [3:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic              arvalid,
  input  logic              arready,
  input  logic [3:0]        rid,
  input  logic [31:0]       rdata,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready
);

  localparam int unsigned OFS       = $clog2(LINE_W / 8);
  localparam logic [31:0] LINE_MASK = ~((32'd1 << OFS) - 32'd1);

  state_e      r_state;
  state_e      w_state_nxt;
  grant_e      r_grant;
  grant_e      w_win;
  logic        w_grant_go;
  logic        w_beat_ok;
  logic [3:0]  r_arid;
  logic [31:0] r_araddr;
  logic [3:0]  r_arlen;
  logic [2:0]  r_arsize;
  logic [1:0]  r_arburst;

`ifdef AXI_RD_RR_EN
  logic r_rr_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr <= 1'b0;
    end else if (w_grant_go && (w_win != G_UNCACHE)) begin
      r_rr_ptr <= ~r_rr_ptr;
    end
  end

  always_comb begin
    w_win = G_ICACHE;
    if (req[2]) begin
      w_win = G_UNCACHE;
    end else if (req[1] && req[0]) begin
      w_win = r_rr_ptr ? G_ICACHE : G_DCACHE;
    end else if (req[1]) begin
      w_win = G_DCACHE;
    end
  end
`else
  always_comb begin
    w_win = G_ICACHE;
    if (req[2]) begin
      w_win = G_UNCACHE;
    end else if (req[1]) begin
      w_win = G_DCACHE;
    end
  end
`endif

  assign w_beat_ok = (r_state == S_R) && rvalid && (rid == r_arid);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_go  = 1'b0;
    arvalid     = 1'b0;
    rready      = 1'b0;
    done        = '0;
    case (r_state)
      S_IDLE: begin
        if (|req) begin
          w_grant_go  = 1'b1;
          w_state_nxt = S_AR;
        end
      end
      S_AR: begin
        arvalid = 1'b1;
        if (arready) begin
          w_state_nxt = S_R;
        end
      end
      S_R: begin
        rready = 1'b1;
        if (w_beat_ok && rlast) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        done        = grant_onehot(r_grant);
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_grant   <= G_ICACHE;
      r_arid    <= '0;
      r_araddr  <= '0;
      r_arlen   <= '0;
      r_arsize  <= '0;
      r_arburst <= '0;
    end else if (w_grant_go) begin
      r_grant   <= w_win;
      r_arburst <= BURST_INCR;
      case (w_win)
        G_UNCACHE: begin
          r_arid   <= ARID_UNCACHE;
          r_araddr <= uc_addr;
          r_arlen  <= '0;
          r_arsize <= uc_size;
        end
        G_DCACHE: begin
          r_arid   <= ARID_DCACHE;
          r_araddr <= dc_addr & LINE_MASK;
          r_arlen  <= 4'(BEATS - 1);
          r_arsize <= SIZE_4B;
        end
        default: begin
          r_arid   <= ARID_ICACHE;
          r_araddr <= ic_addr & LINE_MASK;
          r_arlen  <= 4'(BEATS - 1);
          r_arsize <= SIZE_4B;
        end
      endcase
    end
  end

  assign arid    = r_arid;
  assign araddr  = r_araddr;
  assign arlen   = r_arlen;
  assign arsize  = r_arsize;
  assign arburst = r_arburst;

  axi_rd_linebuf #(
    .BEATS  (BEATS),
    .LINE_W (LINE_W)
  ) u_linebuf (
    .clk           (clk),
    .rst           (rst),
    .i_start       (w_grant_go),
    .i_clear_upper (w_win == G_UNCACHE),
    .i_we          (w_beat_ok),
    .i_wdata       (rdata),
    .o_line        (line_data)
  );

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Randomized self-checking bench for axi_rd_arbiter against a transaction-level
// model of grant choice, AR payload and assembled line contents.
module tb_axi_rd_arbiter;

  localparam int BEATS = 16;
  localparam int LW    = 512;

  logic          clk = 1'b0;
  logic          rst;
  logic [2:0]    req;
  logic [31:0]   ic_addr, dc_addr, uc_addr;
  logic [2:0]    uc_size;
  logic [LW-1:0] line_data;
  logic [2:0]    done;
  logic [3:0]    arid;
  logic [31:0]   araddr;
  logic [3:0]    arlen;
  logic [2:0]    arsize;
  logic [1:0]    arburst;
  logic          arvalid, arready;
  logic [3:0]    rid;
  logic [31:0]   rdata;
  logic          rlast, rvalid, rready;

  always #5 clk = ~clk;

  axi_rd_arbiter #(.BEATS(BEATS), .LINE_W(LW)) dut (
    .clk(clk), .rst(rst), .req(req),
    .ic_addr(ic_addr), .dc_addr(dc_addr), .uc_addr(uc_addr), .uc_size(uc_size),
    .line_data(line_data), .done(done),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  int            chk_cnt  = 0;
  int            pass_cnt = 0;
  int            hs_cnt   = 0;
  logic [LW-1:0] m_line;
  bit            m_rr;

  always @(posedge clk) if (arvalid && arready) hs_cnt++;

  task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // 0 icache, 1 dcache, 2 uncache
  function automatic int pick(input logic [2:0] rq);
    if (rq[2]) return 2;
`ifdef AXI_RD_RR_EN
    if (rq[1] && rq[0]) return m_rr ? 0 : 1;
`endif
    if (rq[1]) return 1;
    return 0;
  endfunction

  task automatic run_txn(input logic [2:0] rq, input bit keep_req, input int ar_delay,
                         input int nbeats, input int junk_pct, input bit seq_data,
                         input logic [31:0] base);
    int          w, k, idx, hs0;
    logic [31:0] ea, d;
    logic [3:0]  el, eid;
    logic [2:0]  es, edone;
    req = rq;
    w   = pick(rq);
    case (w)
      2:       begin ea = uc_addr; el = 4'd0; es = uc_size; end
      1:       begin ea = (dc_addr / 32'(LW/8)) * 32'(LW/8); el = 4'(BEATS-1); es = 3'd2; end
      default: begin ea = (ic_addr / 32'(LW/8)) * 32'(LW/8); el = 4'(BEATS-1); es = 3'd2; end
    endcase
    eid   = 4'(w);
    edone = 3'(1 << w);
`ifdef AXI_RD_RR_EN
    if (w != 2) m_rr = !m_rr;
`endif
    if (w == 2) m_line[LW-1:32] = '0;
    hs0 = hs_cnt;
    @(negedge clk);
    if (!keep_req) req = '0;
    ic_addr = $urandom; dc_addr = $urandom; uc_addr = $urandom; uc_size = 3'($urandom);
    check("arvalid_rise", LW'(arvalid), LW'(1));
    check("arid",    LW'(arid),    LW'(eid));
    check("araddr",  LW'(araddr),  LW'(ea));
    check("arlen",   LW'(arlen),   LW'(el));
    check("arsize",  LW'(arsize),  LW'(es));
    check("arburst", LW'(arburst), LW'(2'b01));
    for (int i = 0; i < ar_delay; i++) begin
      @(negedge clk);
      check("arvalid_hold", LW'(arvalid), LW'(1));
      check("araddr_hold",  LW'(araddr),  LW'(ea));
      check("arlen_hold",   LW'(arlen),   LW'(el));
    end
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    check("arvalid_drop",  LW'(arvalid), LW'(0));
    check("rready_r",      LW'(rready),  LW'(1));
    check("one_handshake", LW'(hs_cnt),  LW'(hs0 + 1));
    k = 0;
    while (k < nbeats) begin
      if (int'($urandom_range(0, 99)) < junk_pct) begin
        rvalid = 1'b1;
        rid    = 4'((int'(eid) + 1 + int'($urandom_range(0, 13))) % 16);
        rdata  = $urandom;
        rlast  = 1'($urandom);
      end else if ($urandom_range(0, 4) == 0) begin
        rvalid = 1'b0; rid = eid; rlast = 1'b1; rdata = $urandom;
      end else begin
        d      = seq_data ? base + 32'(k) : $urandom;
        rvalid = 1'b1; rid = eid; rdata = d; rlast = (k == nbeats - 1);
        idx    = (k < BEATS) ? k : BEATS - 1;
        m_line[32*idx +: 32] = d;
        k++;
      end
      @(negedge clk);
    end
    rvalid = 1'b0; rlast = 1'b0;
    check("done_pulse", LW'(done),   LW'(edone));
    check("line_data",  line_data,   m_line);
    check("rready_off", LW'(rready), LW'(0));
    @(negedge clk);
    check("done_clear", LW'(done), LW'(0));
    check("line_hold",  line_data, m_line);
  endtask

  initial begin
    logic [2:0] rq;
    int         nb;
    rst = 1'b1; req = '0; ic_addr = '0; dc_addr = '0; uc_addr = '0; uc_size = '0;
    arready = 1'b0; rid = '0; rdata = '0; rlast = 1'b0; rvalid = 1'b0;
    m_line = '0; m_rr = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_arvalid", LW'(arvalid), LW'(0));
    check("rst_rready",  LW'(rready),  LW'(0));
    check("rst_done",    LW'(done),    LW'(0));
    check("rst_line",    line_data,    '0);
    check("rst_araddr",  LW'(araddr),  LW'(0));
    check("rst_arlen",   LW'(arlen),   LW'(0));
    check("rst_arsize",  LW'(arsize),  LW'(0));
    check("rst_arid",    LW'(arid),    LW'(0));
    check("rst_arburst", LW'(arburst), LW'(0));
    rst = 1'b0;
    @(negedge clk);

    // simultaneous icache+dcache: dcache first, icache only afterwards
    dc_addr = 32'h1FC0_0044; ic_addr = 32'h0000_1234;
    run_txn(3'b011, 1'b1, 0, 16, 0, 1'b1, 32'hA000_0000);
    ic_addr = 32'h0000_1280;
    run_txn(3'b001, 1'b0, 1, 16, 0, 1'b1, 32'hB000_0000);

    // uncache single word, upper line cleared
    uc_addr = 32'hBFAF_8000; uc_size = 3'd2;
    run_txn(3'b100, 1'b0, 0, 1, 0, 1'b1, 32'hDEAD_BEEF);

    // stalled AR, interleaved foreign-ID beats, saturation, early rlast
    run_txn(3'b010, 1'b0, 5, 16, 10, 1'b0, 32'h0);
    run_txn(3'b001, 1'b0, 0, 16, 40, 1'b1, 32'h0000_0000);
    run_txn(3'b010, 1'b0, 0, 18, 0, 1'b1, 32'h5000_0000);
    run_txn(3'b001, 1'b0, 2, 5, 10, 1'b0, 32'h0);

    // reset in the middle of a dcache burst
    dc_addr = $urandom; req = 3'b010;
    @(negedge clk);
    req = '0; arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    for (int b = 0; b < 7; b++) begin
      rvalid = 1'b1; rid = 4'd1; rdata = $urandom; rlast = 1'b0;
      @(negedge clk);
    end
    rvalid = 1'b1; rid = 4'd1; rdata = $urandom;
    #2 rst = 1'b1;
    #1;
    check("midrst_arvalid", LW'(arvalid), LW'(0));
    check("midrst_rready",  LW'(rready),  LW'(0));
    check("midrst_done",    LW'(done),    LW'(0));
    check("midrst_line",    line_data,    '0);
    check("midrst_araddr",  LW'(araddr),  LW'(0));
    check("midrst_arlen",   LW'(arlen),   LW'(0));
    check("midrst_arid",    LW'(arid),    LW'(0));
    rvalid = 1'b0; m_line = '0; m_rr = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("postrst_done",    LW'(done),    LW'(0));
      check("postrst_arvalid", LW'(arvalid), LW'(0));
    end
    ic_addr = $urandom;
    run_txn(3'b001, 1'b0, 1, 16, 20, 1'b0, 32'h0);

`ifdef AXI_RD_RR_EN
    for (int t = 0; t < 3; t++) run_txn(3'b011, 1'b1, 0, 16, 0, 1'b0, 32'h0);
    req = '0;
    @(negedge clk);
`endif

    for (int t = 0; t < 40; t++) begin
      rq = 3'($urandom_range(1, 7));
      ic_addr = $urandom; dc_addr = $urandom; uc_addr = $urandom; uc_size = 3'($urandom);
      nb = rq[2] ? 1 : int'($urandom_range(1, 18));
      run_txn(rq, 1'($urandom), int'($urandom_range(0, 4)), nb, 20, 1'b0, 32'h0);
    end

    req = '0;
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/axi_rd_arbiter.md
AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter

Interface
REQ-001 Parameter BEATS, default 16: AXI beats per cache line.
REQ-002 Parameter LINE_W, default 512: cache-line width in bits; SHALL equal BEATS*32.
REQ-003 clk  in  1  single system clock; all state changes on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 req  in  3  read requests: bit0 icache miss, bit1 dcache miss, bit2 uncache read.
REQ-006 ic_addr  in  32  icache miss address.
REQ-007 dc_addr  in  32  dcache miss address.
REQ-008 uc_addr  in  32  uncache read address.
REQ-009 uc_size  in  3  uncache AXI transfer size.
REQ-010 line_data  out  LINE_W  returned line; uncache word in [31:0].
REQ-011 done  out  3  one-hot completion pulse, same bit order as req.
REQ-012 arid/araddr/arlen/arsize/arburst  out  4/32/4/3/2  AXI AR payload.
REQ-013 arvalid  out  1, arready  in  1  AR handshake.
REQ-014 rid  in  4, rdata  in  32, rlast  in  1, rvalid  in  1  AXI R channel; rresp ignored.
REQ-015 rready  out  1  R channel ready.

Function
REQ-016 States: IDLE, AR, R, DONE; one transaction in flight at a time.
REQ-017 IDLE: on any req bit set, latch winner, address and size, go to AR next cycle; arvalid rises the cycle after req is sampled.
REQ-018 Priority: uncache > dcache > icache; no preemption of a granted transaction.
REQ-019 AR: arvalid=1, payload held stable until arvalid&&arready; then go to R.
REQ-020 arid = 0/1/2 for icache/dcache/uncache; arburst = 2'b01 (INCR).
REQ-021 Cache grant: arlen = BEATS-1, arsize = 3'b010, araddr = address with low log2(LINE_W/8) bits zeroed.
REQ-022 Uncache grant: arlen = 0, arsize = uc_size, araddr = uc_addr unmodified.
REQ-023 R: rready=1; a beat is accepted when rvalid&&rready&&rid==arid; beats with mismatched rid are dropped and do not advance the counter.
REQ-024 Accepted beat k is written to line_data[32k+31:32k]; the beat counter saturates at BEATS-1, so excess beats overwrite the top word.
REQ-025 An accepted beat with rlast=1 ends R and moves to DONE; words not received keep their prior values.
REQ-026 DONE: pulse done[grant] for exactly one cycle with line_data valid; line_data holds until the next grant's first beat; req is not sampled in DONE; next state is IDLE.
REQ-027 Uncache: line_data[LINE_W-1:32] is cleared at grant.
REQ-028 A req dropped mid-transaction does not abort it; done still pulses.
REQ-029 Requests that arrive while busy wait; arbitration happens only in IDLE.

Reset
REQ-030 On rst: state=IDLE; arvalid, rready, done, line_data, counter and all AR payload outputs = 0.
REQ-031 Reset mid-transaction abandons it with no done pulse; the first grant after reset follows REQ-017.

Configuration
REQ-032 AXI_RD_RR_EN defined: icache/dcache arbitration is round-robin, with the pointer toggling after each cache grant; uncache remains highest priority.
REQ-033 AXI_RD_RR_EN undefined: fixed priority per REQ-018 and no pointer state.

Structure
REQ-034 Shared package holds the AXI ID constants, BURST_INCR, SIZE_4B, the state enum and CACHELINE_WIDTH from the common defines.
REQ-035 One sub-module, axi_rd_linebuf, holds the beat counter, word write enable and line register.

Verification
REQ-036 req=3'b011 in the same cycle, dc_addr=0x1FC0_0044 -> arid=1, araddr=0x1FC0_0040, arlen=15; icache is served only after done=3'b010.
REQ-037 uncache req, uc_addr=0xBFAF_8000, uc_size=2, rdata=0xDEAD_BEEF with rlast -> arlen=0, line_data=0x...0000_DEAD_BEEF with upper bits zero, done=3'b100 one cycle.
REQ-038 arready held low for 5 cycles -> arvalid and payload stable all 5 cycles; exactly one AR handshake.
REQ-039 Beats with rid=3 interleaved into an icache burst -> ignored; line_data holds words 0..15 in order.
REQ-040 rst asserted at beat 7 of a dcache burst -> outputs 0 immediately, no done; a new icache req then completes normally.
REQ-041 With AXI_RD_RR_EN, req=3'b011 held continuously -> grants alternate dcache, icache, dcache.
